// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/grant/rvalid handshake
// plus the valid/ready delivery port toward the IF/ID register.
interface fetch_sequencer_if #(
    parameter int a_width = 8
);
    logic               imem_req_o;
    logic [a_width-1:0] imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [31:0]        imem_rdata_i;
    logic               if_valid_o;
    logic               if_ready_i;
    logic [a_width-1:0] if_pc_o;
    logic [31:0]        if_instr_o;

    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
    );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32I instruction-fetch controller: owns the fetch PC, keeps at most one imem
// request in flight, delivers {pc, instr} via valid/ready and applies EX redirects.
module fetch_sequencer #(
    parameter int               a_width  = 8,
    parameter logic [a_width-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [a_width-1:0] redirect_pc_i,
    output logic               flush_o,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, KILL, HOLD} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t             state_q, state_d;
    logic [a_width-1:0] pc_q, pc_d;
    logic [a_width-1:0] fetch_pc_q, fetch_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [a_width-1:0] if_pc_q, if_pc_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic               flush_q, flush_d;
    logic               imem_req;
    logic               issue;
    logic [a_width-1:0] redir_pc;

    // Targets are word aligned; low bits of the redirect address are dropped.
    assign redir_pc = redirect_pc_i & ~a_width'(3);
    assign issue    = bus.imem_gnt_i && !stall_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        flush_d    = redirect_i;
        imem_req   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_i) pc_d = redir_pc;
            end
            REQ: begin
                imem_req = !stall_i;
                if (redirect_i) begin
                    pc_d = redir_pc;
                    // A grant racing the redirect leaves an orphan response to drain.
                    if (issue) state_d = KILL;
                end else if (issue) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + a_width'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i && redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (bus.imem_rvalid_i) begin
                    if_instr_d = bus.imem_rdata_i;
                    if_pc_d    = fetch_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = HOLD;
                end else if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = KILL;
                end
            end
            KILL: begin
                if (redirect_i) pc_d = redir_pc;
                if (bus.imem_rvalid_i) state_d = REQ;
            end
            HOLD: begin
                if (redirect_i) begin
                    if_valid_d = 1'b0;
                    pc_d       = redir_pc;
                    state_d    = REQ;
                end else if (bus.if_ready_i) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.imem_req_o  = imem_req;
    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.if_pc_o     = if_pc_q;
    assign bus.if_instr_o  = if_instr_q;
    assign flush_o         = flush_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a transaction-level model (expected next fetch address,
// in-flight request list, held instruction) checked every cycle under directed and random traffic.
module tb_fetch_sequencer;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          flush;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.a_width(AW)) bus ();

    fetch_sequencer #(.a_width(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .flush_o(flush), .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            killed;
    } ent_t;

    int n_tests = 0, n_fail = 0;

    // stimulus knobs (percentages / delay range)
    int gnt_pct, stall_pct, redir_pct, ready_pct, dly_min, dly_max;

    // memory side
    bit            mem_busy;
    int            mem_dly;
    logic [AW-1:0] mem_addr;

    // reference model
    ent_t          oq[$];
    logic [AW-1:0] exp_addr, exp_pc, last_pc, last_gnt_addr;
    bit            exp_valid, first, prev_redir;
    int            n_deliv, n_gnt;

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_knobs(input int g, input int s, input int r, input int rd,
                             input int dmin, input int dmax);
        gnt_pct = g; stall_pct = s; redir_pct = r; ready_pct = rd;
        dly_min = dmin; dly_max = dmax;
    endtask

    task automatic rand_inputs();
        stall          = ($urandom_range(99) < stall_pct);
        redirect       = ($urandom_range(99) < redir_pct);
        redirect_pc    = AW'($urandom);
        bus.if_ready_i = ($urandom_range(99) < ready_pct);
    endtask

    // One clock cycle: entered and left at posedge+1 with stall/redirect/ready already driven.
    task automatic tick();
        logic          c_req, c_gnt, c_rv, c_redir, c_rdy, c_stall;
        logic [AW-1:0] c_addr, c_rpc;
        ent_t          e;
        bit            deliver;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        if (mem_busy) begin
            mem_dly--;
            if (mem_dly == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = memf(mem_addr);
                mem_busy = 1'b0;
            end
        end
        #1;
        bus.imem_gnt_i = bus.imem_req_o && ($urandom_range(99) < gnt_pct);
        #1;
        chk("imem_addr", 32'(bus.imem_addr_o), 32'(exp_addr));
        chk("imem_req", 32'(bus.imem_req_o),
            32'(!stall && oq.size() == 0 && !exp_valid && !first));
        chk("if_valid", 32'(bus.if_valid_o), 32'(exp_valid));
        chk("flush", 32'(flush), 32'(prev_redir));
        if (exp_valid) begin
            chk("if_pc", 32'(bus.if_pc_o), 32'(exp_pc));
            chk("if_instr", bus.if_instr_o, memf(exp_pc));
        end
        c_req = bus.imem_req_o; c_gnt = bus.imem_gnt_i; c_rv = bus.imem_rvalid_i;
        c_redir = redirect; c_rdy = bus.if_ready_i; c_stall = stall;
        c_addr = bus.imem_addr_o; c_rpc = redirect_pc;
        @(posedge clk);
        #1;
        deliver = 1'b0;
        if (c_redir) foreach (oq[i]) oq[i].killed = 1'b1;
        if (c_rv && oq.size() > 0) begin
            e = oq.pop_front();
            deliver = !e.killed;
        end
        if (c_req && c_gnt && !c_stall) begin
            oq.push_back('{addr: c_addr, killed: c_redir});
            n_gnt++;
            last_gnt_addr = c_addr;
            mem_busy = 1'b1;
            mem_dly  = $urandom_range(dly_max, dly_min);
            mem_addr = c_addr;
        end
        if (exp_valid && c_rdy && !c_redir) begin
            n_deliv++;
            last_pc = exp_pc;
        end
        if (c_redir || c_rdy) exp_valid = 1'b0;
        if (deliver) begin
            exp_valid = 1'b1;
            exp_pc    = e.addr;
        end
        if (c_redir) exp_addr = c_rpc & 8'hFC;
        else if (c_req && c_gnt && !c_stall) exp_addr = exp_addr + 8'd4;
        prev_redir = c_redir;
        first      = 1'b0;
        redirect   = 1'b0;
    endtask

    task automatic step();
        rand_inputs();
        tick();
    endtask

    task automatic run_deliver(input string tag);
        int d0;
        d0 = n_deliv;
        for (int k = 0; k < 80 && n_deliv == d0; k++) step();
        if (n_deliv == d0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wait_state(input string tag);
        for (int k = 0; k < 40 && oq.size() == 0; k++) step();
        if (oq.size() == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0; bus.if_ready_i = 1'b0;
        #1;
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr_o), 32'h00);
        chk("rst_valid", 32'(bus.if_valid_o), 32'd0);
        chk("rst_pc", 32'(bus.if_pc_o), 32'h00);
        chk("rst_instr", bus.if_instr_o, 32'h0000_0013);
        chk("rst_flush", 32'(flush), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        oq.delete();
        exp_addr = 8'h00; exp_valid = 1'b0; exp_pc = '0;
        first = 1'b1; prev_redir = 1'b0; mem_busy = 1'b0; mem_dly = 0;
    endtask

    initial begin
        logic [AW-1:0] a0, hpc;
        int            g0;
        n_deliv = 0; n_gnt = 0; last_pc = '0; last_gnt_addr = '0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0; bus.if_ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();

        // zero-wait memory: one instruction per 3 cycles from 0x00
        set_knobs(100, 0, 0, 100, 1, 1);
        for (int i = 0; i < 15; i++) step();
        chk("t1_count", 32'(n_deliv), 32'd4);
        chk("t1_last_pc", 32'(last_pc), 32'h0C);

        // redirect while waiting for a slow response
        set_knobs(100, 0, 0, 100, 3, 3);
        wait_wait_state("t2");
        rand_inputs();
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        chk("t2_flush_pulse", 32'(flush), 32'd1);
        chk("t2_next_addr", 32'(bus.imem_addr_o), 32'h40);
        run_deliver("t2");
        chk("t2_pc", 32'(last_pc), 32'h40);

        // IF/ID back-pressure holds the instruction
        set_knobs(100, 0, 0, 0, 1, 1);
        for (int k = 0; k < 40 && !exp_valid; k++) step();
        chk("t3_valid", 32'(bus.if_valid_o), 32'd1);
        hpc = exp_pc;
        for (int i = 0; i < 5; i++) step();
        chk("t3_pc_stable", 32'(bus.if_pc_o), 32'(hpc));
        set_knobs(100, 0, 0, 100, 1, 1);
        g0 = n_gnt;
        for (int k = 0; k < 20 && n_gnt == g0; k++) step();
        chk("t3_next_req", 32'(last_gnt_addr), 32'(hpc + 8'd4));

        // stall in REQ freezes the request
        for (int k = 0; k < 20 && !(oq.size() == 0 && !exp_valid); k++) step();
        a0 = exp_addr;
        g0 = n_gnt;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1'b1;
            tick();
        end
        chk("t4_addr_held", 32'(bus.imem_addr_o), 32'(a0));
        chk("t4_no_grant", 32'(n_gnt), 32'(g0));
        for (int k = 0; k < 20 && n_gnt == g0; k++) step();
        chk("t4_same_addr", 32'(last_gnt_addr), 32'(a0));

        // PC wrap and unaligned redirect target
        rand_inputs();
        redirect = 1'b1; redirect_pc = 8'hF8;
        tick();
        run_deliver("t5a");
        chk("t5_pc_f8", 32'(last_pc), 32'hF8);
        run_deliver("t5b");
        chk("t5_pc_fc", 32'(last_pc), 32'hFC);
        run_deliver("t5c");
        chk("t5_pc_wrap", 32'(last_pc), 32'h00);
        rand_inputs();
        redirect = 1'b1; redirect_pc = 8'h43;
        tick();
        chk("t5_aligned_addr", 32'(bus.imem_addr_o), 32'h40);
        run_deliver("t5d");
        chk("t5_pc_40", 32'(last_pc), 32'h40);

        // asynchronous reset in the middle of a fetch
        set_knobs(100, 0, 0, 100, 3, 3);
        wait_wait_state("t6");
        reset_dut();
        set_knobs(100, 0, 0, 100, 1, 1);
        run_deliver("t6");
        chk("t6_restart_pc", 32'(last_pc), 32'h00);

        // random traffic
        set_knobs(60, 20, 8, 60, 1, 4);
        g0 = n_deliv;
        for (int i = 0; i < 3000; i++) step();
        chk("rand_progress", 32'(n_deliv > g0 + 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
